bram_stream_reader: RTL and testbench

Read-side sequencer for the 256×12 coefficient block RAMs, which have one write port, one read port and a 1-cycle read latency. On `start` it walks `len` consecutive addresses from `base` on the RAM read port, modulo 256. It hides the 1-cycle read latency and presents the coefficients as a valid/ready stream with backpressure. It sits between a polynomial BRAM and the next consumer in the datapath, such as the output unloader or an inter-PE transfer.

---
 rtl/bram_stream_reader.sv | 159 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side sequencer for a 1-cycle-latency coefficient BRAM. On start it
//   walks len consecutive addresses from base (mod 2^AW). It hides the read
//   latency behind a 2-entry output FIFO and presents the coefficients as a
//   valid/ready stream with backpressure.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start/base/len    burst request; sampled only while idle (busy=0)
//   raddr             BRAM read address (combinational from regs + m_ready)
//   bram_dout         BRAM read data, valid the cycle after raddr
//   m_valid/m_data/m_last/m_ready   output stream
//   busy              burst in progress
//   done              one-cycle pulse after the last beat is accepted
module bram_stream_reader #(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] bram_dout,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic          vld;
    logic          last;
    logic [DW-1:0] data;
  } ent_t;

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   icnt;      // reads issued so far
  logic [AW:0]   wcnt;      // beats written into the FIFO so far
  logic [AW-1:0] raddr_q;
  logic          inflight;  // read issued last cycle; bram_dout valid now
  ent_t          hd, tl;    // FIFO head (drives the stream) and tail
  logic          done_q;

  logic          pop, push, issue, start_ok, done_nxt;
  logic [1:0]    lvl, thresh;
  ent_t          wr;

  assign pop      = hd.vld & m_ready;
  assign push     = inflight;
  assign start_ok = (state == IDLE) & start;

  // Entries that will exist once the in-flight read lands. Issuing only
  // while (FIFO + inflight - pop) <= 1 guarantees the next push always has
  // a free slot even if the consumer stalls from now on.
  assign lvl    = {1'b0, hd.vld} + {1'b0, tl.vld} + {1'b0, inflight};
  assign thresh = {1'b0, pop} + 2'd1;
  assign issue  = (state == RUN) && (lvl <= thresh);

  // Address is presented in the issue cycle itself; otherwise hold the
  // last address (a stray BRAM read is harmless).
  assign raddr = issue ? (base_q + icnt[AW-1:0]) : raddr_q;

  assign wr.vld  = 1'b1;
  assign wr.data = bram_dout;
  assign wr.last = (wcnt == len_q - ONE);

  assign m_valid = hd.vld;
  assign m_data  = hd.data;
  assign m_last  = hd.vld & hd.last;
  assign busy    = (state != IDLE);
  assign done    = done_q;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) state_nxt = RUN;
          else           done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (issue && (icnt == len_q - ONE)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && hd.last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      icnt     <= '0;
      wcnt     <= '0;
      raddr_q  <= '0;
      inflight <= 1'b0;
      hd       <= '0;
      tl       <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_q   <= done_nxt;
      inflight <= issue;
      raddr_q  <= raddr;

      if (start_ok) begin
        base_q <= base;
        len_q  <= len;
        icnt   <= '0;
        wcnt   <= '0;
      end else begin
        if (issue) icnt <= icnt + ONE;
        if (push)  wcnt <= wcnt + ONE;
      end

      // FIFO: head always holds the oldest entry; data field of an empty
      // head is left as-is so m_data only changes on a new beat.
      case ({pop, push})
        2'b11: begin
          if (tl.vld) begin
            hd <= tl;
            tl <= wr;
          end else begin
            hd <= wr;
          end
        end
        2'b10: begin
          if (tl.vld) hd <= tl;
          else        hd.vld <= 1'b0;
          tl.vld <= 1'b0;
        end
        2'b01: begin
          if (!hd.vld) hd <= wr;
          else         tl <= wr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural 256x12 BRAM
// preloaded mem[a] = a + 0x100.
module tb_bram_stream_reader;

  localparam int DW = 12;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, start, m_ready;
  logic [AW-1:0] base, raddr;
  logic [AW:0]   len;
  logic [DW-1:0] bram_dout, m_data;
  logic          m_valid, m_last, busy, done;

  logic [DW-1:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) bram_dout <= mem[raddr];

  bram_stream_reader #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
    .raddr(raddr), .bram_dout(bram_dout), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input int b, input int l);
    @(negedge clk);
    start = 1'b1;
    base  = AW'(b);
    len   = (AW+1)'(l);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one burst starting at edge 0. mode 0: m_ready=1, with cycle-exact
  // timing and raddr checks; mode 1: random m_ready. inj: pulse a
  // conflicting start in cycle 2 that must be ignored.
  task automatic run_burst(input int b, input int l, input int mode, input bit inj);
    int cyc, beat, maxd, d, seen;
    cyc = 0; beat = 0; maxd = 0; seen = 0;
    m_ready = 1'b1;
    do_start(b, l);
    while (cyc < l * 4 + 20 && !seen) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        d = (int'(raddr) - b - beat) & 255;
        if (d > maxd) maxd = d;
      end
      if (mode == 0 && cyc <= l)
        chk("raddr", raddr, (b + cyc - 1) & 255);
      if (m_valid && m_ready) begin
        chk("data", m_data, ((b + beat) & 255) + 'h100);
        chk("last", m_last, beat == l - 1);
        if (mode == 0) chk("beat_cyc", cyc, beat + 3);
        beat++;
      end
      if (done) begin
        seen = 1;
        chk("beats", beat, l);
        chk("busy@done", busy, 0);
        if (mode == 0) chk("done_cyc", cyc, l + 3);
      end
      start = 1'b0;
      if (inj && cyc == 2) begin
        start = 1'b1; base = 8'h80; len = 9'd3;
      end
      if (mode == 1) m_ready = 1'($urandom_range(0, 1));
    end
    chk("done_seen", seen, 1);
    chk("outstanding", maxd <= 2, 1);
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    int beat, vhi;
    for (int a = 0; a < 256; a++) mem[a] = DW'(a + 'h100);
    reset = 1'b1; start = 1'b0; m_ready = 1'b1; base = '0; len = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_data", m_data, 0);

    run_burst('h10, 4, 0, 0);     // basic
    run_burst('hFE, 4, 0, 0);     // wrap
    run_burst('h30, 16, 1, 0);    // random backpressure
    run_burst('h05, 1, 0, 0);     // single beat
    run_burst(0, 256, 0, 0);      // full depth
    run_burst('h50, 6, 0, 1);     // start while busy ignored

    // len = 0: done in cycle 1, no beats
    do_start('h33, 0);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    vhi = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid || done) vhi = 1;
    end
    chk("len0_quiet", vhi, 0);

    // reset mid-burst after 5 accepted beats
    do_start('h40, 20);
    beat = 0;
    for (int c = 0; c < 40 && beat < 5; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) beat++;
    end
    chk("pre_rst_beats", beat, 5);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_data", m_data, 0);
    reset = 1'b0;
    vhi = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || m_valid) vhi = 1;
    end
    chk("post_rst_quiet", vhi, 0);
    run_burst('h20, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
